// File: rtl/rs_enc_lfsr_if.sv
// Symbol stream bundle for the RS(K+4,K) encoder: data-in handshake and codeword-out flags.
interface rs_enc_lfsr_if;
  logic [7:0] enc_din;
  logic       enc_din_valid;
  logic       enc_din_ready;
  logic [7:0] enc_dout;
  logic       enc_dout_valid;
  logic       enc_dout_sop;
  logic       enc_dout_eop;

  modport master (
    output enc_din, enc_din_valid,
    input  enc_din_ready, enc_dout, enc_dout_valid, enc_dout_sop, enc_dout_eop
  );

  modport slave (
    input  enc_din, enc_din_valid,
    output enc_din_ready, enc_dout, enc_dout_valid, enc_dout_sop, enc_dout_eop
  );
endinterface

// File: rtl/rs_enc_lfsr.sv
// Systematic RS encoder over GF(2^8), 4 parity symbols: data passes through, then the LFSR
// remainder of d(x)*x^4 mod g(x) is shifted out high-degree first.
module rs_enc_lfsr #(
  parameter int K = 16
) (
  input  logic         clk,
  input  logic         rst,
  rs_enc_lfsr_if.slave bus
);

  typedef enum logic [1:0] {
    S_DATA   = 2'b01,
    S_PARITY = 2'b10
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(K - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q;
  logic [1:0] pcnt_q;
  logic [7:0] r0, r1, r2, r3;
  logic [7:0] dout_q;
  logic       valid_q, sop_q, eop_q;
  logic       din_ready, accept;
  logic [7:0] fb;

  // Constant-coefficient multiply in GF(2^8) mod 0x11D; collapses to XOR trees when b is fixed.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  assign din_ready = (state_q == S_DATA) && !rst;
  assign accept    = bus.enc_din_valid && din_ready;
  assign fb        = bus.enc_din ^ r3;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DATA:   if (accept && (cnt_q == LAST_IDX)) state_d = S_PARITY;
      S_PARITY: if (pcnt_q == 2'd3) state_d = S_DATA;
      default:  state_d = S_DATA;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_DATA;
    end else begin
      state_q <= state_d;
    end
  end

  // Parity shift-out leaves r0..r3 zero, so the next codeword needs no explicit clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 8'd0;
      pcnt_q  <= 2'd0;
      r0      <= 8'h00;
      r1      <= 8'h00;
      r2      <= 8'h00;
      r3      <= 8'h00;
      dout_q  <= 8'h00;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      if (state_q == S_PARITY) begin
        dout_q  <= r3;
        valid_q <= 1'b1;
        eop_q   <= (pcnt_q == 2'd3);
        r3      <= r2;
        r2      <= r1;
        r1      <= r0;
        r0      <= 8'h00;
        pcnt_q  <= pcnt_q + 2'd1;
      end else if (accept) begin
        dout_q  <= bus.enc_din;
        valid_q <= 1'b1;
        sop_q   <= (cnt_q == 8'd0);
        r3      <= r2 ^ gf_mul(fb, 8'h0F);
        r2      <= r1 ^ gf_mul(fb, 8'h36);
        r1      <= r0 ^ gf_mul(fb, 8'h78);
        r0      <= gf_mul(fb, 8'h40);
        cnt_q   <= (cnt_q == LAST_IDX) ? 8'd0 : cnt_q + 8'd1;
      end
    end
  end

  assign bus.enc_din_ready  = din_ready;
  assign bus.enc_dout       = dout_q;
  assign bus.enc_dout_valid = valid_q;
  assign bus.enc_dout_sop   = sop_q;
  assign bus.enc_dout_eop   = eop_q;

endmodule
